// File: rtl/bt_loader_pkg.sv
// Shared types and constants for the Bluetooth program loader.
package bt_loader_pkg;

    localparam int         LEN_W     = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/bt_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start confirm at half bit, centre sampling.
// byte_valid / frame_err are one-cycle pulses issued at the stop-bit centre.
module uart_rx
    import bt_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int            BIT_CYC  = CLK_FREQ / BAUD;
    localparam int            CW       = $clog2(BIT_CYC);
    localparam logic [CW-1:0] BIT_RLD  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_RLD = CW'(BIT_CYC / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Start needs a high-to-low edge, so a line held low after a bad stop bit is not re-read as a start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = HALF_RLD;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s) begin
                    state_d = RX_DATA;
                    cnt_d   = BIT_RLD;
                    bit_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = BIT_RLD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    valid_d = rx_s;
                    err_d   = !rx_s;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: rtl/bt_program_loader.sv
// Frame parser that writes a serial program image into instruction memory and holds the CPU meanwhile.
// Define BT_LOADER_CSUM_EN to expect and check a trailing XOR checksum byte.
module bt_program_loader
    import bt_loader_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int MEM_DEPTH   = 1024,
    parameter int TIMEOUT_CYC = CLK_FREQ / 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_data,
    output logic        prog_we,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMO_RLD   = TW'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W:0] DEPTH_MAX = (LEN_W + 1)'(MEM_DEPTH);

    logic [7:0]       byte_data;
    logic             byte_valid, frame_err;

    loader_state_t    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, addr_q, addr_d;
    logic [LEN_W-1:0] len_new, idx_inc;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [31:0]      asm_q, asm_d, data_q, data_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
    logic             in_frame;
`ifdef BT_LOADER_CSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign len_new  = {byte_data, len_q[7:0]};
    assign idx_inc  = idx_q + LEN_W'(1);
    assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA) ||
                      (state_q == WRITE)  || (state_q == CSUM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BT_LOADER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BT_LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        data_d  = data_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef BT_LOADER_CSUM_EN
        csum_d  = csum_q;
`endif
        if (byte_valid)         tmo_d = TMO_RLD;
        else if (tmo_q != '0)   tmo_d = tmo_q - TW'(1);
        else                    tmo_d = tmo_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d = LEN_LO;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    idx_d   = '0;
`ifdef BT_LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN_LO: begin
                if (byte_valid) begin
                    len_d[7:0] = byte_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (byte_valid) begin
                    len_d  = len_new;
                    bcnt_d = '0;
                    if ({1'b0, len_new} > DEPTH_MAX) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (len_new == '0) begin
`ifdef BT_LOADER_CSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_valid) begin
                    case (bcnt_q)
                        2'd0:    asm_d[7:0]   = byte_data;
                        2'd1:    asm_d[15:8]  = byte_data;
                        2'd2:    asm_d[23:16] = byte_data;
                        default: asm_d[31:24] = byte_data;
                    endcase
`ifdef BT_LOADER_CSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        data_d  = asm_d;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
`ifdef BT_LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef BT_LOADER_CSUM_EN
            CSUM: begin
                if (byte_valid) begin
                    if (byte_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Line faults and stalls abort the frame wherever it is; cpu_hold stays asserted.
        if (in_frame && (frame_err || (tmo_q == '0 && !byte_valid))) begin
            state_d = ERROR;
            err_d   = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
            we_d    = 1'b0;
        end
    end

    assign prog_addr  = {{(32 - LEN_W){1'b0}}, addr_q};
    assign prog_data  = data_q;
    assign prog_we    = we_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_bt_program_loader.sv
// Randomized frame bench for bt_program_loader; expected writes/status are derived from the frame bytes.
module tb_bt_program_loader;

    localparam int CLK_FREQ    = 160;
    localparam int BAUD        = 10;
    localparam int MEM_DEPTH   = 1024;
    localparam int TIMEOUT_CYC = 400;
    localparam int BIT         = CLK_FREQ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] prog_addr, prog_data;
    logic        prog_we, cpu_hold, load_done, load_error;

    always #5 clk = ~clk;

    bt_program_loader #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .MEM_DEPTH   (MEM_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_we    (prog_we),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] wr_log[$];
    logic [7:0]  frm[$];

    always @(negedge clk) if (prog_we) wr_log.push_back({prog_addr, prog_data});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic check_status(input string tag, input logic h, input logic d, input logic e);
        check({tag, "_hold"}, cpu_hold, h);
        check({tag, "_done"}, load_done, d);
        check({tag, "_err"}, load_error, e);
    endtask

    // Sends frm, then compares the writes and final status against values decoded from the bytes.
    task automatic run_frame(input string tag);
        int          base, n, n_w;
        logic        ok;
        logic [31:0] w;
        logic [63:0] got;
`ifdef BT_LOADER_CSUM_EN
        logic [7:0]  x;
`endif
        base = wr_log.size();
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i], 1'b1);
            if (i == 0) check_status({tag, "_sync"}, 1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        n = int'(frm[1]) + 256 * int'(frm[2]);
        ok = 1'b1;
        n_w = n;
        if (n > MEM_DEPTH) begin
            ok = 1'b0;
            n_w = 0;
        end
`ifdef BT_LOADER_CSUM_EN
        x = 8'h00;
        for (int i = 0; i < 4 * n_w; i++) x ^= frm[3 + i];
        if (n_w == n && ok) ok = (frm[3 + 4 * n] == x);
`endif
        check({tag, "_nwr"}, 64'(wr_log.size() - base), 64'(n_w));
        for (int i = 0; i < n_w; i++) begin
            w = {frm[6 + 4 * i], frm[5 + 4 * i], frm[4 + 4 * i], frm[3 + 4 * i]};
            got = (base + i < wr_log.size()) ? wr_log[base + i] : 64'hDEAD_DEAD_DEAD_DEAD;
            check($sformatf("%s_wr%0d", tag, i), got, {32'(i), w});
            if (i == n_w - 1) check({tag, "_hold_addr"}, {prog_addr, prog_data}, {32'(i), w});
        end
        check_status({tag, "_end"}, !ok, ok, !ok);
    endtask

    task automatic build_random();
        int         n;
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        if ($urandom_range(0, 7) == 0) n = $urandom_range(MEM_DEPTH + 1, 3000);
        else                           n = $urandom_range(0, 4);
        frm = {8'hA5, 8'(n), 8'(n >> 8)};
        if (n <= MEM_DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x ^= b;
                frm.push_back(b);
            end
`ifdef BT_LOADER_CSUM_EN
            if ($urandom_range(0, 2) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            frm.push_back(x);
`endif
        end
    endtask

    task automatic build_good();
        frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef BT_LOADER_CSUM_EN
        frm.push_back(8'h90);
`endif
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_flags", {prog_we, cpu_hold, load_done, load_error}, 4'h0);
        check("rst_bus", {prog_addr, prog_data}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after", {prog_we, cpu_hold, load_done, load_error}, 4'h0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        pulse_reset();
        repeat (5) @(negedge clk);

        build_good();
        run_frame("good");
        check("good_words", {wr_log[0][31:0], wr_log[1][31:0]}, 64'h0000_0013_0010_0093);

`ifdef BT_LOADER_CSUM_EN
        build_good();
        frm[frm.size() - 1] = 8'h91;
        run_frame("badcsum");
`endif

        frm = {8'hA5, 8'h01, 8'h04};
        run_frame("oversize");
        build_good();
        run_frame("after_over");

        // Stall inside a word: no error just short of the timeout, error just past it.
        base = wr_log.size();
        frm = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        foreach (frm[i]) send_byte(frm[i], 1'b1);
        repeat (TIMEOUT_CYC - 100) @(negedge clk);
        check("tmo_early_err", load_error, 1'b0);
        repeat (150) @(negedge clk);
        check_status("tmo", 1'b1, 1'b0, 1'b1);
        check("tmo_nwr", 64'(wr_log.size() - base), 64'd0);

        pulse_reset();
        base = wr_log.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        check("junk_flags", {prog_we, cpu_hold, load_done, load_error}, 4'h0);
        check("junk_nwr", 64'(wr_log.size() - base), 64'd0);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (20) @(negedge clk);
        check_status("badstop", 1'b1, 1'b0, 1'b1);
        check("badstop_nwr", 64'(wr_log.size() - base), 64'd0);

        frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        foreach (frm[i]) send_byte(frm[i], 1'b1);
        repeat (3) @(negedge clk);
        pulse_reset();
        repeat (5) @(negedge clk);
        build_good();
        run_frame("post_rst");

        for (int k = 0; k < 10; k++) begin
            build_random();
            run_frame($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bt_program_loader.md
# bt_program_loader

Receives a program image over the Bluetooth serial link (UART, 8N1) and writes it word-by-word into the instruction memory through its programming write port. It sits between the Bluetooth module's TX pin and the instruction memory's `prog_addr`/`prog_data`/`prog_we` inputs. It holds the CPU in reset while a load is in progress.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: serial bit rate.
- `MEM_DEPTH`, default 1024: instruction memory depth in words; also the maximum accepted word count.
- `TIMEOUT_CYC`, default `CLK_FREQ/10`: maximum idle cycles between bytes inside a frame.

- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `rx` in 1: serial data from the Bluetooth module; idles high and is asynchronous to `clk`.
- `prog_addr` out 32: word index (not a byte address) for the memory write.
- `prog_data` out 32: word to write.
- `prog_we` out 1: one-cycle write strobe.
- `cpu_hold` out 1: high while loading or after a failed load; drives the CPU reset.
- `load_done` out 1: level; the last frame completed correctly.
- `load_error` out 1: level; the last frame failed.

## Operation
- Frame format, in byte order:
  - sync byte `0xA5`
  - `LEN_LO`, `LEN_HI`: 16-bit word count N
  - N words, each 4 bytes, little-endian
  - `CSUM`: XOR of all word bytes
- State machine states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE, DONE, ERROR:
  - Any byte other than `0xA5` is ignored.
  - `0xA5` goes to LEN_LO, clears `load_done`/`load_error`, sets `cpu_hold`, and clears the word index.
- LEN_HI:
  - N > `MEM_DEPTH` goes to ERROR; no writes occur.
  - N = 0 goes straight to CSUM, with expected checksum `0x00`.
- DATA:
  - Bytes shift into the 32-bit assembly register: byte k lands in bits [8k+7:8k].
  - The running XOR is updated on every data byte.
  - After the 4th byte, go to WRITE.
- WRITE: lasts one cycle.
  - Asserts `prog_we` with `prog_addr` = word index.
  - Then increments the index.
  - Returns to DATA, or goes to CSUM once the index equals N.
- CSUM:
  - A match goes to DONE: `load_done`=1, `cpu_hold`=0.
  - A mismatch goes to ERROR: `load_error`=1, `cpu_hold` stays 1.
- Timeout: in LEN_LO, LEN_HI, DATA or CSUM, if `TIMEOUT_CYC` cycles pass without a byte, go to ERROR. The counter reloads on every received byte.
- A framing error (stop bit sampled 0) inside a frame goes to ERROR. In IDLE/DONE/ERROR the byte is simply dropped.
- Words already written before an ERROR stay in memory. `cpu_hold` keeps the CPU from running them.

## Timing
- Every output is 0 during reset and in the first cycle after `rst_n` rises.
- `rx` passes through a 2-flop synchronizer before use.
- Bit sampling:
  - A start edge is confirmed at half a bit period.
  - Data bits are sampled at bit centres, every `CLK_FREQ/BAUD` cycles (integer division).
  - `byte_valid` pulses for one cycle at the centre of the stop bit.
- `prog_we` rises exactly 1 cycle after the `byte_valid` of the 4th byte of a word.
  - `prog_addr` and `prog_data` are stable in that cycle.
  - Both hold their values afterwards until the next write.
- `load_done`/`load_error` change 1 cycle after the `byte_valid` of the checksum byte. `cpu_hold` changes in the same cycle.
- `cpu_hold` rises 1 cycle after the `byte_valid` of the sync byte.
- If `rst_n` goes low mid-frame, the block returns to IDLE on the next edge: all outputs 0 and the partial word discarded.
- A `byte_valid` that coincides with WRITE cannot occur: bytes are at least 10 bit periods apart.

## Configuration
- `BT_LOADER_CSUM_EN`:
  - Defined: the CSUM byte is expected and checked as above.
  - Undefined: there is no CSUM state and no XOR register. After the last WRITE (or LEN_HI with N=0) the block goes directly to DONE, 1 cycle after the final `prog_we`.

## Structure
- Package `bt_loader_pkg` holds:
  - the state enum `loader_state_t`
  - `SYNC_BYTE = 8'hA5`
  - the frame-length width (16).
- Sub-module `uart_rx`:
  - ports: `clk`, `rst_n`, `rx`, `byte_data[7:0]`, `byte_valid`, `frame_err`
  - parameterised by `CLK_FREQ` and `BAUD`
  - contains the synchronizer and baud counter.
- The top level holds the frame FSM, the word assembler, the index counter, the timeout counter and the checksum.

## Test plan
- Good frame `A5 02 00 13 00 00 00 93 00 10 00 90`:
  - Writes (0, `0x00000013`) then (1, `0x00100093`).
  - Then `load_done`=1, `cpu_hold`=0, `load_error`=0.
- Same frame with CSUM `0x91`:
  - Both writes occur.
  - Then `load_error`=1, `cpu_hold`=1, `load_done`=0.
- `A5 01 04` with `MEM_DEPTH`=1024 (N=1025):
  - `load_error`=1, zero `prog_we` pulses.
  - A following valid frame loads normally.
- `A5 01 00 13 00`, then silence for `TIMEOUT_CYC`+1 cycles:
  - `load_error`=1, no write.
- Bytes `00 FF 5A` in IDLE:
  - No output change.
  - A stop-bit-0 byte mid-DATA gives `load_error`=1.
- `rst_n` low for 1 cycle after the 2nd data byte:
  - All outputs 0 on the next edge.
  - A fresh frame completes with `prog_addr` starting at 0.
